// File: rtl/div_unit_32bit.sv
// -----------------------------------------------------------------------------
// div_unit_32bit
//
// Iterative 32-bit divider for RV32M DIV/DIVU/REM/REMU. It uses restoring
// division and produces one quotient bit per cycle. It has no subtractor of its
// own. While dividing, it drives the core's shared add/subtract stage through
// add_a/add_b/add_sub and uses add_sum/add_cout in the same cycle.
//
// Sequence per operation: IDLE -> PREP -> DIV (32 cycles) -> FIX -> IDLE.
// A divide by zero skips DIV.
//
// Ports
//   clk       rising-edge clock
//   rst       asynchronous, active-high reset
//   start     launch request, only looked at in IDLE
//   op        00 DIV, 01 DIVU, 10 REM, 11 REMU
//   dividend  rs1 operand, captured with start
//   divisor   rs2 operand, captured with start
//   busy      high from the cycle after start is accepted until the done cycle
//   done      one-cycle result-valid pulse
//   result    quotient or remainder, held until the next done
//   add_a     shared adder operand A (0 outside DIV)
//   add_b     shared adder operand B (0 outside DIV)
//   add_sub   shared adder mode, 1 = A - B (0 outside DIV)
//   add_sum   shared adder result
//   add_cout  shared adder carry-out, 1 = no borrow
// -----------------------------------------------------------------------------
module div_unit_32bit (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  output logic        busy,
  output logic        done,
  output logic [31:0] result,
  output logic [31:0] add_a,
  output logic [31:0] add_b,
  output logic        add_sub,
  input  logic [31:0] add_sum,
  input  logic        add_cout
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_PREP,
    S_DIV,
    S_FIX
  } state_t;

  state_t      state;
  state_t      state_next;

  logic [1:0]  op_q;
  logic [31:0] dvd_q;     // original dividend, kept for the divide-by-zero REM result
  logic [31:0] dvs_q;     // raw divisor until PREP, then |divisor|
  logic [31:0] quo;       // dividend bits shift out of the top, quotient bits shift in at the bottom
  logic [31:0] rem;
  logic [4:0]  cnt;
  logic        neg_q;
  logic        neg_r;
  logic        bypass;

  logic        is_signed;
  logic [31:0] dvd_abs;
  logic [31:0] dvs_abs;
  logic [31:0] shifted;
  logic        take;
  logic [31:0] quo_fix;
  logic [31:0] rem_fix;

  // Datapath helpers. Every output depends only on registered state, except
  // take, which also needs the adder carry.
  always_comb begin
    is_signed = ~op_q[0];
    dvd_abs   = (is_signed && dvd_q[31]) ? (32'd0 - dvd_q) : dvd_q;
    dvs_abs   = (is_signed && dvs_q[31]) ? (32'd0 - dvs_q) : dvs_q;
    shifted   = {rem[30:0], quo[31]};
    // rem[31] is bit 32 of the shifted partial remainder. When it is set, the
    // remainder is above any 32-bit divisor, so the subtraction is always taken.
    take      = rem[31] | add_cout;
    quo_fix   = neg_q ? (32'd0 - quo) : quo;
    rem_fix   = neg_r ? (32'd0 - rem) : rem;
  end

  // State register.
  // NOTE: sequential state uses non-blocking assignments. All flops then
  // update together, and readers in the same edge see the old values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  // Next-state logic.
  // NOTE: every always_comb output gets a default first. This prevents any
  // path from leaving a value unassigned and inferring a latch.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: if (start) state_next = S_PREP;
      S_PREP: state_next = (dvs_q == 32'd0) ? S_FIX : S_DIV;
      S_DIV:  if (cnt == 5'd31) state_next = S_FIX;
      S_FIX:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Shared adder drive. It is active only during the iterations and idle at zero.
  always_comb begin
    add_a   = 32'd0;
    add_b   = 32'd0;
    add_sub = 1'b0;
    if (state == S_DIV) begin
      add_a   = shifted;
      add_b   = dvs_q;
      add_sub = 1'b1;
    end
  end

  // Datapath and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q   <= 2'd0;
      dvd_q  <= 32'd0;
      dvs_q  <= 32'd0;
      quo    <= 32'd0;
      rem    <= 32'd0;
      cnt    <= 5'd0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      bypass <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
      result <= 32'd0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            op_q  <= op;
            dvd_q <= dividend;
            dvs_q <= divisor;
            busy  <= 1'b1;
          end
        end
        S_PREP: begin
          quo    <= dvd_abs;
          dvs_q  <= dvs_abs;
          rem    <= 32'd0;
          cnt    <= 5'd0;
          neg_q  <= is_signed & (dvd_q[31] ^ dvs_q[31]);
          neg_r  <= is_signed & dvd_q[31];
          bypass <= (dvs_q == 32'd0);
        end
        S_DIV: begin
          rem <= take ? add_sum : shifted;
          quo <= {quo[30:0], take};
          cnt <= cnt + 5'd1;
        end
        S_FIX: begin
          if (bypass) result <= op_q[1] ? dvd_q : 32'hFFFF_FFFF;
          else        result <= op_q[1] ? rem_fix : quo_fix;
          bypass <= 1'b0;
          busy   <= 1'b0;
          done   <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
